// File: rtl/issuer_pkg.sv
// Shared definitions for the instruction issuer: opcodes, zoom limits, status codes,
// FSM encoding and instruction word field positions.
package issuer_pkg;

    // Opcode encodings, identical to memory_control.
    localparam logic [2:0] OP_RD  = 3'b001;
    localparam logic [2:0] OP_WR  = 3'b010;
    localparam logic [2:0] OP_NHI = 3'b011;
    localparam logic [2:0] OP_PR  = 3'b100;
    localparam logic [2:0] OP_NH  = 3'b101;
    localparam logic [2:0] OP_BA  = 3'b110;

    localparam logic [2:0] ZOOM_RESET = 3'b100;
    localparam logic [2:0] ZOOM_MAX   = 3'b110;
    localparam logic [2:0] ZOOM_MIN   = 3'b010;

    localparam logic [1:0] ST_OK         = 2'b00;
    localparam logic [1:0] ST_ILLEGAL    = 2'b01;
    localparam logic [1:0] ST_ZOOM_LIMIT = 2'b10;
    localparam logic [1:0] ST_TIMEOUT    = 2'b11;

    localparam int OPC_LSB   = 0;
    localparam int OPC_MSB   = 2;
    localparam int ADDR_LSB  = 3;
    localparam int ADDR_MSB  = 19;
    localparam int COLOR_LSB = 20;
    localparam int COLOR_MSB = 27;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_RESPOND   = 3'd5
    } state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op != 3'b000) && (op != 3'b111);
    endfunction

    function automatic logic is_zoom_in(input logic [2:0] op);
        return (op == OP_NHI) || (op == OP_PR);
    endfunction

    function automatic logic is_zoom_out(input logic [2:0] op);
        return (op == OP_NH) || (op == OP_BA);
    endfunction

endpackage

// File: rtl/instruction_issuer_if.sv
// Bundle of host-side and memory_control-side signals of the instruction issuer.
interface instruction_issuer_if;
    import issuer_pkg::*;

    // Host handshake: an instruction transfers on a rising clock edge where
    // instr_valid && instr_ready; resp_valid is a one-cycle pulse with no back-pressure.
    logic [31:0] instr_data;
    logic        instr_valid;
    logic        instr_ready;
    logic        resp_valid;
    logic [1:0]  resp_status;
    logic [7:0]  resp_rd_data;
    logic [2:0]  zoom_level;
    logic        busy;

    logic [2:0]  mc_operation;
    logic [16:0] mc_addr;
    logic [7:0]  mc_color;
    logic [2:0]  mc_zoom;
    logic        mc_enable;
    logic        mc_done;
    logic [7:0]  mem_rd_data;

    modport master (
        input  instr_data, instr_valid, mc_done, mem_rd_data,
        output instr_ready, resp_valid, resp_status, resp_rd_data, zoom_level, busy,
               mc_operation, mc_addr, mc_color, mc_zoom, mc_enable
    );

    modport slave (
        output instr_data, instr_valid, mc_done, mem_rd_data,
        input  instr_ready, resp_valid, resp_status, resp_rd_data, zoom_level, busy,
               mc_operation, mc_addr, mc_color, mc_zoom, mc_enable
    );

endinterface

// File: rtl/issuer_watchdog.sv
// Load/count/expire counter bounding the wait for memory_control to finish.
module issuer_watchdog #(
    parameter int           W     = 18,
    parameter logic [W-1:0] LIMIT = '1
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic count_en,
    output logic expired
);

    logic [W-1:0] count;

    // The load cycle counts as the first elapsed cycle, so expiry lands on cycle LIMIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= {{(W-1){1'b0}}, 1'b1};
        end else if (count_en && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = count_en && (count == LIMIT - 1'b1);

endmodule

// File: rtl/instruction_issuer.sv
// Command front end for memory_control: decode, issue, wait for done, respond.
// Optional watchdog enabled by defining ISSUER_TIMEOUT_EN.
module instruction_issuer
    import issuer_pkg::*;
#(
    parameter int                   TIMEOUT_W      = 18,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 18'd262143
) (
    input  logic                 clock,
    input  logic                 reset,
    instruction_issuer_if.master bus,
    output state_t               state_dbg
);

    state_t      state, state_next;
    logic [2:0]  op_q;
    logic [16:0] addr_q;
    logic [7:0]  color_q;
    logic [2:0]  mc_op_q;
    logic [16:0] mc_addr_q;
    logic [7:0]  mc_color_q;
    logic [2:0]  zoom_q;
    logic [1:0]  status_q;
    logic [7:0]  rd_q;

    logic        accept;
    logic        decode_err;
    logic [1:0]  decode_status;
    logic        finish_ok;
    logic        timeout_hit;
    logic        wd_expired;
    logic        unused_reserved;

    assign unused_reserved = ^bus.instr_data[31:28];
    assign accept          = bus.instr_valid && bus.instr_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        decode_err    = 1'b0;
        decode_status = ST_OK;
        finish_ok     = 1'b0;
        timeout_hit   = 1'b0;

        if (!is_legal_op(op_q)) begin
            decode_err    = 1'b1;
            decode_status = ST_ILLEGAL;
        end else if ((is_zoom_in(op_q) && zoom_q == ZOOM_MAX) ||
                     (is_zoom_out(op_q) && zoom_q == ZOOM_MIN)) begin
            decode_err    = 1'b1;
            decode_status = ST_ZOOM_LIMIT;
        end

        case (state)
            S_IDLE: begin
                if (accept) state_next = S_DECODE;
            end
            S_DECODE: begin
                // A previous run (possibly one orphaned by reset) must finish first.
                if (decode_err)       state_next = S_RESPOND;
                else if (bus.mc_done) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                state_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (wd_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = S_RESPOND;
                end else if (!bus.mc_done) begin
                    state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (bus.mc_done) begin
                    finish_ok  = 1'b1;
                    state_next = S_RESPOND;
                end else if (wd_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = S_RESPOND;
                end
            end
            S_RESPOND: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q       <= 3'b000;
            addr_q     <= '0;
            color_q    <= '0;
            mc_op_q    <= 3'b000;
            mc_addr_q  <= '0;
            mc_color_q <= '0;
            zoom_q     <= ZOOM_RESET;
            status_q   <= ST_OK;
            rd_q       <= '0;
        end else begin
            if (accept) begin
                op_q    <= bus.instr_data[OPC_MSB:OPC_LSB];
                addr_q  <= bus.instr_data[ADDR_MSB:ADDR_LSB];
                color_q <= bus.instr_data[COLOR_MSB:COLOR_LSB];
            end
            // Bus fields only change when a legal op is about to launch.
            if (state == S_DECODE && state_next == S_ISSUE) begin
                mc_op_q    <= op_q;
                mc_addr_q  <= addr_q;
                mc_color_q <= color_q;
            end
            if (state == S_DECODE && decode_err) begin
                status_q <= decode_status;
            end
            if (finish_ok) begin
                status_q <= ST_OK;
                if (op_q == OP_RD) rd_q <= bus.mem_rd_data;
                if (is_zoom_in(op_q))       zoom_q <= zoom_q + 3'd1;
                else if (is_zoom_out(op_q)) zoom_q <= zoom_q - 3'd1;
            end
            if (timeout_hit) begin
                status_q <= ST_TIMEOUT;
            end
        end
    end

`ifdef ISSUER_TIMEOUT_EN
    logic wd_load;
    logic wd_count;

    assign wd_load  = (state == S_ISSUE);
    assign wd_count = (state == S_WAIT_ACK) || (state == S_WAIT_DONE);

    issuer_watchdog #(
        .W     (TIMEOUT_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .load     (wd_load),
        .count_en (wd_count),
        .expired  (wd_expired)
    );
`else
    logic unused_timeout_cfg;

    assign wd_expired         = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    assign bus.instr_ready  = (state == S_IDLE) && !reset;
    assign bus.busy         = (state != S_IDLE);
    assign bus.resp_valid   = (state == S_RESPOND);
    assign bus.resp_status  = status_q;
    assign bus.resp_rd_data = rd_q;
    assign bus.zoom_level   = zoom_q;
    assign bus.mc_zoom      = zoom_q;
    assign bus.mc_enable    = (state == S_ISSUE);
    assign bus.mc_operation = mc_op_q;
    assign bus.mc_addr      = mc_addr_q;
    assign bus.mc_color     = mc_color_q;
    assign state_dbg        = state;

endmodule

// File: tb/tb_instruction_issuer.sv
// Self-checking bench for instruction_issuer: reset values, a directed vector table,
// multi-cycle corner sequences and randomized instructions against a reference model.
module tb_instruction_issuer;
  import issuer_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  instruction_issuer_if bus_if();
  state_t state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  // memory_control stand-in: done drops the cycle after enable, stays low mc_lat cycles
  logic       mc_done_r = 1'b1;
  logic [7:0] mem_r = 8'h00;
  int         mc_cnt = 0;
  int         mc_lat = 1;
  logic [7:0] mc_rd_val = 8'h00;
  bit         mc_force_low = 1'b0;

  // reference model state
  int         m_zoom = 4;
  logic [7:0] m_rdd = 8'h00;

  typedef struct {
    logic [2:0]  op;
    logic [16:0] addr;
    logic [7:0]  col;
    logic [7:0]  rd;
    int          lat;
    logic [1:0]  st;
    logic [2:0]  zoom;
    logic [7:0]  rdd;
    int          exp_lat;
  } vec_t;

  vec_t vt[17];

  assign bus_if.mc_done     = mc_done_r;
  assign bus_if.mem_rd_data = mem_r;

  instruction_issuer #(.TIMEOUT_W(18), .TIMEOUT_CYCLES(18'd16)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus_if),
    .state_dbg (state_dbg)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mc_force_low) begin
      mc_done_r <= 1'b0;
      mem_r     <= 8'($urandom);
    end else if (bus_if.mc_enable) begin
      mc_done_r <= 1'b0;
      mc_cnt    <= mc_lat;
      mem_r     <= 8'($urandom);
    end else if (mc_cnt == 1) begin
      mc_done_r <= 1'b1;
      mc_cnt    <= 0;
      mem_r     <= mc_rd_val;
    end else begin
      if (mc_cnt > 1) mc_cnt <= mc_cnt - 1;
      else if (!mc_done_r) mc_done_r <= 1'b1;
      mem_r <= 8'($urandom);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: outcome of one instruction from the opcode rules and zoom limits.
  function automatic void model_exec(input logic [2:0] op, input logic [7:0] rd, input int lat,
                                     output logic [1:0] st, output int e_lat, output int e_en);
    bit zin, zout;
    zin  = (op == 3'd3) || (op == 3'd4);
    zout = (op == 3'd5) || (op == 3'd6);
    if (op == 3'd0 || op == 3'd7) st = 2'b01;
    else if ((zin && m_zoom == 6) || (zout && m_zoom == 2)) st = 2'b10;
    else begin
      st = 2'b00;
      if (zin) m_zoom = m_zoom + 1;
      if (zout) m_zoom = m_zoom - 1;
      if (op == 3'd1) m_rdd = rd;
    end
    e_lat = (st == 2'b00) ? lat + 4 : 2;
    e_en  = (st == 2'b00) ? 1 : 0;
  endfunction

  task automatic run_instr(input logic [2:0] op, input logic [16:0] addr, input logic [7:0] col,
                           input logic [7:0] rd, input int lat,
                           output int got_lat, output int got_en, output logic [1:0] got_st,
                           output logic [7:0] got_rdd, output bit bus_ok);
    bit seen;
    int w;
    got_lat = -1; got_en = 0; bus_ok = 1'b1; seen = 1'b0; got_st = 2'bxx; got_rdd = 8'hxx;
    mc_lat = lat; mc_rd_val = rd;
    w = 0;
    while (!bus_if.instr_ready && w < 50) begin @(negedge clock); w++; end
    bus_if.instr_data  = {4'($urandom_range(0, 15)), col, addr, op};
    bus_if.instr_valid = 1'b1;
    @(negedge clock);
    bus_if.instr_valid = 1'b0;
    bus_if.instr_data  = $urandom;
    for (int c = 1; c <= 60; c++) begin
      if (bus_if.mc_enable) begin got_en++; seen = 1'b1; end
      if (seen && (bus_if.mc_operation !== op || bus_if.mc_addr !== addr || bus_if.mc_color !== col))
        bus_ok = 1'b0;
      if (bus_if.resp_valid) begin
        got_lat = c; got_st = bus_if.resp_status; got_rdd = bus_if.resp_rd_data;
        @(negedge clock);
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic do_txn(input string tag, input logic [2:0] op, input logic [16:0] addr,
                        input logic [7:0] col, input logic [7:0] rd, input int lat,
                        input logic [1:0] e_st, input logic [2:0] e_zoom, input logic [7:0] e_rdd,
                        input int e_lat, input int e_en);
    int g_lat, g_en;
    logic [1:0] g_st;
    logic [7:0] g_rdd;
    bit g_bus;
    run_instr(op, addr, col, rd, lat, g_lat, g_en, g_st, g_rdd, g_bus);
    check({tag, " latency"}, g_lat, e_lat);
    check({tag, " enables"}, g_en, e_en);
    check({tag, " status"}, g_st, e_st);
    check({tag, " rd_data"}, g_rdd, e_rdd);
    check({tag, " bus held"}, g_bus, 1);
    check({tag, " zoom"}, bus_if.zoom_level, e_zoom);
    check({tag, " mc_zoom"}, bus_if.mc_zoom, e_zoom);
    check({tag, " pulse width"}, bus_if.resp_valid, 0);
    check({tag, " status held"}, bus_if.resp_status, e_st);
  endtask

  initial begin
    logic [1:0] e_st;
    int e_lat, e_en, en, rdy, rv, bsy, g_lat, w;
    logic [2:0] op_at;
    logic [16:0] addr_at;
    logic [2:0] rop;

    bus_if.instr_data  = '0;
    bus_if.instr_valid = 1'b0;

    // reset values
    repeat (3) @(negedge clock);
    check("rst instr_ready", bus_if.instr_ready, 0);
    check("rst resp_valid", bus_if.resp_valid, 0);
    check("rst resp_status", bus_if.resp_status, 0);
    check("rst resp_rd_data", bus_if.resp_rd_data, 0);
    check("rst zoom", bus_if.zoom_level, 3'b100);
    check("rst busy", bus_if.busy, 0);
    check("rst mc_enable", bus_if.mc_enable, 0);
    check("rst mc_operation", bus_if.mc_operation, 0);
    check("rst mc_addr", bus_if.mc_addr, 0);
    check("rst mc_color", bus_if.mc_color, 0);
    check("rst state", state_dbg, S_IDLE);
    reset = 1'b0;
    @(negedge clock);
    check("post-rst instr_ready", bus_if.instr_ready, 1);

    // directed vectors: op addr col rd lat | status zoom rd_data latency
    vt[0]  = '{3'b010, 17'd100,   8'hA5, 8'h00, 3, 2'b00, 3'b100, 8'h00, 7};
    vt[1]  = '{3'b001, 17'd19200, 8'h00, 8'h3C, 3, 2'b00, 3'b100, 8'h3C, 7};
    vt[2]  = '{3'b011, 17'd5,     8'h00, 8'h00, 2, 2'b00, 3'b101, 8'h3C, 6};
    vt[3]  = '{3'b011, 17'd6,     8'h00, 8'h00, 1, 2'b00, 3'b110, 8'h3C, 5};
    vt[4]  = '{3'b011, 17'd7,     8'h00, 8'h00, 1, 2'b10, 3'b110, 8'h3C, 2};
    vt[5]  = '{3'b101, 17'd8,     8'h00, 8'h00, 2, 2'b00, 3'b101, 8'h3C, 6};
    vt[6]  = '{3'b111, 17'd9,     8'h11, 8'h00, 1, 2'b01, 3'b101, 8'h3C, 2};
    vt[7]  = '{3'b000, 17'd10,    8'h22, 8'h00, 1, 2'b01, 3'b101, 8'h3C, 2};
    vt[8]  = '{3'b100, 17'd11,    8'h00, 8'h00, 1, 2'b00, 3'b110, 8'h3C, 5};
    vt[9]  = '{3'b100, 17'd12,    8'h00, 8'h00, 1, 2'b10, 3'b110, 8'h3C, 2};
    vt[10] = '{3'b110, 17'd13,    8'h00, 8'h00, 2, 2'b00, 3'b101, 8'h3C, 6};
    vt[11] = '{3'b101, 17'd14,    8'h00, 8'h00, 1, 2'b00, 3'b100, 8'h3C, 5};
    vt[12] = '{3'b110, 17'd15,    8'h00, 8'h00, 3, 2'b00, 3'b011, 8'h3C, 7};
    vt[13] = '{3'b101, 17'd16,    8'h00, 8'h00, 4, 2'b00, 3'b010, 8'h3C, 8};
    vt[14] = '{3'b110, 17'd17,    8'h00, 8'h00, 1, 2'b10, 3'b010, 8'h3C, 2};
    vt[15] = '{3'b010, 17'h1FFFF, 8'hFF, 8'h77, 1, 2'b00, 3'b010, 8'h3C, 5};
    vt[16] = '{3'b001, 17'd0,     8'h00, 8'hC9, 2, 2'b00, 3'b010, 8'hC9, 6};
    for (int i = 0; i < 17; i++) begin
      model_exec(vt[i].op, vt[i].rd, vt[i].lat, e_st, e_lat, e_en);
      do_txn($sformatf("vec%0d", i), vt[i].op, vt[i].addr, vt[i].col, vt[i].rd, vt[i].lat,
             vt[i].st, vt[i].zoom, vt[i].rdd, vt[i].exp_lat, (vt[i].st == 2'b00) ? 1 : 0);
    end

    // mc_done held low at accept: no launch until it rises, busy-time offers ignored
    mc_force_low = 1'b1;
    repeat (2) @(negedge clock);
    bus_if.instr_data  = {4'h0, 8'h5A, 17'd777, OP_WR};
    bus_if.instr_valid = 1'b1;
    @(negedge clock);
    bus_if.instr_data = {4'h0, 8'hFF, 17'd1, OP_RD};
    en = 0; rdy = 0; rv = 0;
    for (int k = 0; k < 6; k++) begin
      en += int'(bus_if.mc_enable); rdy += int'(bus_if.instr_ready); rv += int'(bus_if.resp_valid);
      @(negedge clock);
    end
    check("held no enable", en, 0);
    check("held not ready", rdy, 0);
    check("held no resp", rv, 0);
    mc_force_low = 1'b0; mc_lat = 2;
    en = 0; g_lat = -1; op_at = 3'b000; addr_at = '0; rdy = 0;
    for (int c = 0; c < 40; c++) begin
      rdy += int'(bus_if.instr_ready);
      if (bus_if.mc_enable) begin en++; op_at = bus_if.mc_operation; addr_at = bus_if.mc_addr; end
      if (bus_if.resp_valid) begin
        g_lat = c; bus_if.instr_valid = 1'b0;
        check("held status", bus_if.resp_status, 2'b00);
        @(negedge clock);
        break;
      end
      @(negedge clock);
    end
    bus_if.instr_valid = 1'b0;
    check("held responded", (g_lat >= 0), 1);
    check("held enable count", en, 1);
    check("held busy-ready", rdy, 0);
    check("held op issued", op_at, OP_WR);
    check("held addr issued", addr_at, 17'd777);
    rv = 0; bsy = 0;
    for (int k = 0; k < 3; k++) begin
      rv += int'(bus_if.resp_valid); bsy += int'(bus_if.busy);
      @(negedge clock);
    end
    check("held no second accept", bsy, 0);
    check("held no extra resp", rv, 0);

    // randomized instructions against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [16:0] ra;
      logic [7:0] rc, rr;
      int rl;
      rop = 3'($urandom_range(0, 7));
      ra = 17'($urandom); rc = 8'($urandom); rr = 8'($urandom);
      rl = $urandom_range(1, 4);
      model_exec(rop, rr, rl, e_st, e_lat, e_en);
      do_txn($sformatf("rnd%0d", i), rop, ra, rc, rr, rl, e_st, 3'(m_zoom), m_rdd, e_lat, e_en);
    end

    // reset during WAIT_DONE drops the instruction
    mc_lat = 5; mc_rd_val = 8'hEE;
    bus_if.instr_data = {4'h0, 8'h00, 17'd4242, OP_RD};
    bus_if.instr_valid = 1'b1;
    @(negedge clock);
    bus_if.instr_valid = 1'b0;
    w = 0;
    while (!bus_if.mc_enable && w < 20) begin @(negedge clock); w++; end
    check("midrst enable seen", bus_if.mc_enable, 1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst resp_valid", bus_if.resp_valid, 0);
    check("midrst busy", bus_if.busy, 0);
    check("midrst instr_ready", bus_if.instr_ready, 0);
    check("midrst mc_enable", bus_if.mc_enable, 0);
    check("midrst mc_operation", bus_if.mc_operation, 0);
    check("midrst mc_addr", bus_if.mc_addr, 0);
    check("midrst mc_color", bus_if.mc_color, 0);
    check("midrst zoom", bus_if.zoom_level, 3'b100);
    check("midrst status", bus_if.resp_status, 0);
    check("midrst rd_data", bus_if.resp_rd_data, 0);
    @(negedge clock);
    reset = 1'b0;
    rv = 0;
    for (int k = 0; k < 8; k++) begin @(negedge clock); rv += int'(bus_if.resp_valid); end
    check("midrst no resp", rv, 0);
    m_zoom = 4; m_rdd = 8'h00;
    w = 0;
    while (!bus_if.mc_done && w < 20) begin @(negedge clock); w++; end
    model_exec(OP_NHI, 8'h00, 2, e_st, e_lat, e_en);
    do_txn("after reset", OP_NHI, 17'd3, 8'h00, 8'h00, 2, e_st, 3'(m_zoom), m_rdd, e_lat, e_en);

`ifdef ISSUER_TIMEOUT_EN
    // done never returns: status 11 sixteen cycles after ISSUE, zoom unchanged
    do_txn("timeout", OP_RD, 17'd55, 8'h00, 8'h11, 10000, 2'b11, 3'(m_zoom), m_rdd, 18, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_issuer.md
# instruction_issuer

Command front end for `memory_control`. It accepts 32-bit instruction words from the host over a valid/ready handshake and decodes opcode, address and colour. It drives `memory_control`'s `operation`/`addr_base`/`enable`/`color_in`/`current_zoom` inputs, tracks the zoom level, and waits out the `done` handshake. It then returns one response per instruction: status plus read data.

## Interface
Parameters:
- `TIMEOUT_W`, default 18: width of the watchdog counter.
- `TIMEOUT_CYCLES`, default 18'd262143: maximum cycles from `mc_enable` until `mc_done` returns high.

Ports (one clock; reset is asynchronous and active-high):
- `clock` in 1: sole clock, all logic on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `instr_data` in 32: [2:0] opcode, [19:3] address, [27:20] colour, [31:28] reserved (ignored).
- `instr_valid` in 1: host offers an instruction.
- `instr_ready` out 1: high only in IDLE.
- `resp_valid` out 1: one-cycle pulse per accepted instruction.
- `resp_status` out 2: 00 ok, 01 illegal opcode, 10 zoom limit, 11 timeout; held until next response.
- `resp_rd_data` out 8: read pixel for RD; unchanged for other ops.
- `zoom_level` out 3: current zoom, also drives `mc_zoom`.
- `busy` out 1: high in every state except IDLE.
- `mc_operation` out 3: opcode to `memory_control`.
- `mc_addr` out 17: `addr_base` to `memory_control`.
- `mc_color` out 8: `color_in` to `memory_control` (write colour).
- `mc_zoom` out 3: `current_zoom` to `memory_control`.
- `mc_enable` out 1: single-cycle start pulse.
- `mc_done` in 1: `memory_control` done (high = idle).
- `mem_rd_data` in 8: frame-buffer read port data.

## Operation
- Opcodes: 001 RD, 010 WR, 011 NHI, 100 PR, 101 NH, 110 BA. 000 and 111 are illegal.
- Zoom: reset value 3'b100 (1x).
  - NHI and PR are zoom-in: +1, saturating at 3'b110.
  - NH and BA are zoom-out: −1, saturating at 3'b010.
  - An op requested at its limit is not issued; status 10, zoom unchanged.
  - Zoom updates only on successful completion of a zoom op.
- FSM states: IDLE → DECODE → ISSUE → WAIT_ACK → WAIT_DONE → RESPOND → IDLE.
  - **IDLE:** `instr_ready`=1. On `instr_valid&&instr_ready`, latch the fields and go to DECODE.
  - **DECODE:** illegal opcode or zoom limit → RESPOND with error. Otherwise stay in DECODE while `mc_done`=0 (`memory_control` still busy), then go to ISSUE.
  - **ISSUE:** `mc_enable`=1 for exactly this cycle; go to WAIT_ACK.
  - **WAIT_ACK:** wait for `mc_done`=0, then go to WAIT_DONE.
  - **WAIT_DONE:** wait for `mc_done`=1. On that cycle, capture `mem_rd_data` into `resp_rd_data` (RD only), update zoom, go to RESPOND.
  - **RESPOND:** `resp_valid`=1 for one cycle, then go to IDLE.
- `mc_operation`, `mc_addr`, `mc_color`, `mc_zoom` stay stable from ISSUE until WAIT_DONE exits. `memory_control` samples `operation` throughout its run.
- `mc_enable` is never high outside ISSUE, so `memory_control` cannot re-launch when it returns to IDLE.
- `instr_valid` while busy is ignored; no queueing.

## Timing
- Reset values:
  - `instr_ready`=0 during reset, 1 on the first cycle after release.
  - `resp_valid`=0, `resp_status`=00, `resp_rd_data`=0, `zoom_level`=3'b100, `busy`=0.
  - `mc_enable`=0, `mc_operation`=000, `mc_addr`=0, `mc_color`=0.
- Accept to `mc_enable`: 2 cycles when `mc_done`=1 at DECODE.
- Minimum RD/WR turnaround: accept to `resp_valid` is `mc_done` latency + 4 cycles.
- Error path: accept to `resp_valid` is 2 cycles; `mc_enable` never asserted.
- Reset mid-operation drops the instruction with no response and `mc_enable` forced low. `memory_control` finishes its own run; the next DECODE waits for `mc_done`.

## Configuration
- `ISSUER_TIMEOUT_EN` defined:
  - The watchdog counts from ISSUE.
  - Reaching `TIMEOUT_CYCLES` in WAIT_ACK or WAIT_DONE goes to RESPOND with status 11 and zoom unchanged.
  - A later `mc_done` edge is ignored.
- Undefined: no counter; WAIT_ACK/WAIT_DONE wait indefinitely; status 11 is never produced.

## Structure
- Shared package `issuer_pkg`:
  - opcode localparams (identical encodings to `memory_control`);
  - `ZOOM_RESET`/`ZOOM_MAX`/`ZOOM_MIN`;
  - status codes;
  - FSM state encoding;
  - instruction bit-field positions.
- Sub-module `issuer_watchdog`: load/count/expire counter, instantiated only under `ISSUER_TIMEOUT_EN`.

## Test plan
- WR, addr 17'd100, colour 8'hA5, model done drops 1 cycle after enable and rises 3 later → `mc_enable` one pulse with `mc_operation`=010, `mc_addr`=100, `mc_color`=A5 held; `resp_valid` with status 00.
- RD, addr 17'd19200, `mem_rd_data`=8'h3C at done rise → `resp_rd_data`=3C, status 00.
- NHI ×3 from reset → zoom goes 100→101→110; the third gets status 10, no `mc_enable`, zoom stays 110. Then NH → zoom 101.
- Opcode 111, then 000 → status 01 each, 2-cycle response, no `mc_enable`.
- `mc_done` held low at accept → no `mc_enable` until done high; `instr_valid` during busy not accepted. With `ISSUER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, done never rising → status 11 at cycle 16 after ISSUE.
- Reset asserted during WAIT_DONE → all outputs at reset values immediately, no `resp_valid`.
